// File: rtl/spi_master_mc.sv
// Parametrised SPI master: one full-duplex frame per accepted start, all CPOL/CPHA modes,
// runtime bit order, NUM_SS active-low selects with optional hold across bursts.
module spi_master_mc #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int DVSR_W = 16,
    parameter int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic [DVSR_W-1:0] dvsr_i,
    input  logic              start_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsb_first_i,
    input  logic [SS_W-1:0]   ss_sel_i,
    input  logic              ss_hold_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              spi_done_tick_o,
    output logic              ready_o,
    output logic              sclk_o,
    output logic [NUM_SS-1:0] ss_n_o,
    input  logic              miso_i,
    output logic              mosi_o
);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, DLY, P0, P1} state_t;

    state_t            state_q;
    logic [DVSR_W-1:0] cnt_q;
    logic [DVSR_W-1:0] dvsr_q;
    logic [BIT_W-1:0]  bit_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic              cpol_q;
    logic              cpha_q;
    logic              lsb_q;
    logic              hold_q;
    logic              pclk_q;
    logic              accept;
    logic              cnt_done;
    logic              sample_evt;
    logic              shift_evt;

    // Out-of-range selects decode to no active line.
    function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
        logic [NUM_SS-1:0] r;
        r = '1;
        for (int i = 0; i < NUM_SS; i++)
            if (sel == SS_W'(i)) r[i] = 1'b0;
        return r;
    endfunction

    assign accept     = start_i & ready_o;
    assign cnt_done   = (cnt_q == dvsr_q);
    assign sample_evt = (state_q == P0) & cnt_done;
    assign shift_evt  = (state_q == P1) & cnt_done & (bit_q != LAST_BIT);

    // Idle level follows the live cpol_i so a mode change shows on the pin before the next start.
    assign sclk_o = ready_o ? cpol_i : (pclk_q ^ cpol_q);

    // NOTE: datapath registers carry no reset; every bit is loaded or shifted in before it is used.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            tx_q   <= din_i;
            dvsr_q <= dvsr_i;
            cpol_q <= cpol_i;
            cpha_q <= cpha_i;
            lsb_q  <= lsb_first_i;
        end else begin
            if (sample_evt)
                rx_q <= lsb_q ? {miso_i, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso_i};
            if (shift_evt)
                tx_q <= lsb_q ? (tx_q >> 1) : (tx_q << 1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            bit_q           <= '0;
            hold_q          <= 1'b0;
            pclk_q          <= 1'b0;
            ready_o         <= 1'b1;
            spi_done_tick_o <= 1'b0;
            dout_o          <= '0;
            mosi_o          <= 1'b0;
            ss_n_o          <= '1;
        end else begin
            spi_done_tick_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= cpha_i ? DLY : P0;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        pclk_q  <= 1'b0;
                        ready_o <= 1'b0;
                        hold_q  <= ss_hold_i;
                        ss_n_o  <= ss_decode(ss_sel_i);
                        mosi_o  <= lsb_first_i ? din_i[0] : din_i[DATA_W-1];
                    end
                end
                DLY: begin
                    if (cnt_done) begin
                        state_q <= P0;
                        cnt_q   <= '0;
                        pclk_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + DVSR_W'(1);
                    end
                end
                P0: begin
                    if (cnt_done) begin
                        state_q <= P1;
                        cnt_q   <= '0;
                        pclk_q  <= ~cpha_q;
                    end else begin
                        cnt_q <= cnt_q + DVSR_W'(1);
                    end
                end
                P1: begin
                    if (cnt_done) begin
                        cnt_q <= '0;
                        if (bit_q == LAST_BIT) begin
                            state_q         <= IDLE;
                            ready_o         <= 1'b1;
                            spi_done_tick_o <= 1'b1;
                            dout_o          <= rx_q;
                            mosi_o          <= 1'b0;
                            if (!hold_q) ss_n_o <= '1;
                        end else begin
                            state_q <= P0;
                            bit_q   <= bit_q + BIT_W'(1);
                            pclk_q  <= cpha_q;
                            mosi_o  <= lsb_q ? tx_q[1] : tx_q[DATA_W-2];
                        end
                    end else begin
                        cnt_q <= cnt_q + DVSR_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_master_mc.md
Name:
spi_master_mc

Overview:
- Parametrised SPI master, next generation of the single-channel 8-bit SPI engine: configurable frame width, NUM_SS slave-select lines, runtime MSB/LSB-first order, and chip-select hold for multi-frame bursts.
- Sits between a bus-side register wrapper and the chip pins; one full-duplex frame per start_i.
- All four CPOL/CPHA modes; SCLK divided from clk_i by a runtime divisor.

Parameters:
- DATA_W, 8, frame width in bits (>=2).
- NUM_SS, 4, number of active-low slave-select outputs (>=1).
- DVSR_W, 16, width of divisor input.
- SS_W, $clog2(NUM_SS) (min 1), derived width of ss_sel_i; not overridden.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- din_i  in  DATA_W  transmit frame, latched on accepted start.
- dvsr_i  in  DVSR_W  SCLK half-period = dvsr_i+1 clk cycles (H).
- start_i  in  1  start request; accepted only when ready_o=1.
- cpol_i  in  1  SCLK idle level.
- cpha_i  in  1  0: sample leading edge; 1: sample trailing edge.
- lsb_first_i  in  1  1: bit 0 shifted first.
- ss_sel_i  in  SS_W  index of slave to select.
- ss_hold_i  in  1  1: keep selected SS asserted after this frame.
- dout_o  out  DATA_W  last received frame.
- spi_done_tick_o  out  1  one-cycle pulse at frame end.
- ready_o  out  1  engine idle, start accepted.
- sclk_o  out  1  serial clock.
- ss_n_o  out  NUM_SS  active-low selects.
- miso_i  in  1  serial data in.
- mosi_o  out  1  serial data out.

Behaviour:
- Reset (rst_i=1 at edge): state IDLE, ready_o=1, spi_done_tick_o=0, dout_o=0, mosi_o=0, ss_n_o=all 1, bit counter 0, hold flag 0. rst_i overrides a transfer in progress: SS released and no done tick.
- Accept: start_i=1 with ready_o=1 in cycle T latches din_i, dvsr_i, cpol_i, cpha_i, lsb_first_i, ss_sel_i, ss_hold_i. Input changes after T are ignored until the next accept. start_i while busy is ignored, not queued.
- FSM: IDLE -> (cpha=0) P0 | (cpha=1) DLY. DLY(H) -> P0. P0(H) -> P1. P1(H) -> P0 with next bit, or -> IDLE after bit DATA_W-1.
- Divider counter counts 0..H-1 per state and clears on each state change. dvsr_i=0 gives H=1.
- Internal clock pclk = P1 when cpha=0, P0 when cpha=1. sclk_o = pclk XOR latched cpol. In IDLE, sclk_o = live cpol_i.
- mosi_o: current bit of tx shift register, valid from entry to P0 (or DLY for cpha=1). Register shifts on P1->P0.
- Bit order: lsb_first selects bit 0 or bit DATA_W-1 first. Received bits assemble into the same bit positions as transmitted. miso_i is sampled in the last cycle of P0.
- Frame end: in the first IDLE cycle after the last P1, spi_done_tick_o=1 and dout_o updates. dout_o then holds until the next done.
- Latency: done at T+1+2*DATA_W*H, plus H when cpha=1. ready_o rises in the same cycle as the done tick; a start in that cycle is accepted (back-to-back).
- SS: ss_n_o[ss_sel] goes low from T+1 through the last P1 cycle. It deasserts in the done cycle unless the latched hold=1. Held SS stays low in IDLE until one of:
  - a new start with a different ss_sel: old line goes high at T+1, new line low at T+1;
  - a frame with hold=0 completes;
  - rst_i.
- At most one ss_n_o bit is low at any time. ss_sel_i >= NUM_SS: no SS asserted, frame still runs and completes normally.

Test Plan:
- Mode 0, DATA_W=8, dvsr=3, din=0xA5, miso looped to mosi, sel=2 -> 8 SCLK rising edges, first at T+5; ss_n_o=4'b1011 during frame; done at T+65; dout=0xA5.
- Mode 3 (cpol=1, cpha=1), dvsr=0, din=0x3C, miso driven with 0xC3 MSB-first -> sclk_o idles 1, done at T+18, dout=0xC3; repeat in mode 1 and mode 2 -> same data.
- lsb_first=1, din=0x01, loopback -> mosi high only on first bit, dout=0x01; DATA_W=16 build, din=0xBEEF -> dout=0xBEEF after 32 half-periods.
- Burst: frame1 hold=1 sel=0, frame2 hold=0 sel=0 started in the done cycle -> ss_n_o[0] low continuously from frame1 T+1 to frame2 done; start during busy ignored.
- Held SS then start with sel=1 -> ss_n_o[0] high and ss_n_o[1] low at the same edge T+1.
- rst_i asserted mid-frame (bit 4) -> next cycle ready_o=1, ss_n_o all 1, no done tick, dout_o=0.
